// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: diagonally skews unskewed A/B beats for the sa_2D array and
// brackets each job with an accumulator clear and a zero flush.
module sa_skew_feeder #(
    parameter int WIDTH = 8,
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int KW    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [KW-1:0]        K_LEN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH*HPE-1:0] A_IN,
    input  logic [WIDTH*VPE-1:0] B_IN,
    output logic [WIDTH*HPE-1:0] AA,
    output logic [WIDTH*VPE-1:0] BB,
    output logic                 PE_CLR,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int F  = HPE + VPE + ((HPE > VPE) ? HPE : VPE) - 2;
    localparam int FW = $clog2(F + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, FIN} state_t;

    state_t                 state_q;
    logic [KW-1:0]          klen_q, cnt_q, cnt_d;
    logic [FW-1:0]          fcnt_q;
    logic                   ready_q, clr_q, busy_q, done_q;
    logic                   accept;
    logic [WIDTH*HPE-1:0]   a_inj;
    logic [WIDTH*VPE-1:0]   b_inj;

    assign accept   = IN_VALID & ready_q;
    assign cnt_d    = cnt_q + KW'(1);
    // Cycles without an accepted beat inject zeros on both sides, keeping A/B aligned
    assign a_inj    = accept ? A_IN : '0;
    assign b_inj    = accept ? B_IN : '0;
    assign IN_READY = ready_q;
    assign PE_CLR   = clr_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            ready_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    klen_q  <= K_LEN;
                    cnt_q   <= '0;
                    clr_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    clr_q <= 1'b0;
                    if (klen_q != '0) begin
                        ready_q <= 1'b1;
                        state_q <= STREAM;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                STREAM: if (accept) begin
                    cnt_q <= cnt_d;
                    if (cnt_d == klen_q) begin
                        ready_q <= 1'b0;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fcnt_q == FW'(F - 1)) begin
                        fcnt_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Lane i is an (i+1)-deep chain; newest stage at the bottom, output is the top stage
    for (genvar i = 0; i < HPE; i++) begin : g_a
        logic [(i+1)*WIDTH-1:0] ch_q;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) ch_q <= '0;
            else      ch_q <= (ch_q << WIDTH) | ((i+1)*WIDTH)'(a_inj[i*WIDTH +: WIDTH]);
        end
        assign AA[i*WIDTH +: WIDTH] = ch_q[i*WIDTH +: WIDTH];
    end

    for (genvar i = 0; i < VPE; i++) begin : g_b
        logic [(i+1)*WIDTH-1:0] ch_q;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) ch_q <= '0;
            else      ch_q <= (ch_q << WIDTH) | ((i+1)*WIDTH)'(b_inj[i*WIDTH +: WIDTH]);
        end
        assign BB[i*WIDTH +: WIDTH] = ch_q[i*WIDTH +: WIDTH];
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed bench for the skew feeder (4x4 and 2x3 instances),
// with a small output-stationary MAC model fed from the skewed outputs.
module tb_sa_skew_feeder;
    localparam int F = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0, IN_VALID = 1'b0;
    logic [7:0]  K_LEN = '0;
    logic [31:0] A_IN = '0, B_IN = '0;
    logic [31:0] AA, BB;
    logic        IN_READY, PE_CLR, BUSY, DONE;

    logic        START2 = 1'b0, IN_VALID2 = 1'b0;
    logic [7:0]  K_LEN2 = '0;
    logic [15:0] A_IN2 = '0, AA2;
    logic [23:0] B_IN2 = '0, BB2;
    logic        IN_READY2, PE_CLR2, BUSY2, DONE2;

    int          checks = 0, errors = 0;
    logic [7:0]  ha [4][4];
    logic [7:0]  hb [4][4];
    int          acc [4][4];

    sa_skew_feeder #(.WIDTH(8), .HPE(4), .VPE(4), .KW(8)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .K_LEN(K_LEN), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .A_IN(A_IN), .B_IN(B_IN), .AA(AA), .BB(BB),
        .PE_CLR(PE_CLR), .BUSY(BUSY), .DONE(DONE)
    );

    sa_skew_feeder #(.WIDTH(8), .HPE(2), .VPE(3), .KW(8)) u_asym (
        .CLK(CLK), .RST(RST), .START(START2), .K_LEN(K_LEN2), .IN_VALID(IN_VALID2),
        .IN_READY(IN_READY2), .A_IN(A_IN2), .B_IN(B_IN2), .AA(AA2), .BB(BB2),
        .PE_CLR(PE_CLR2), .BUSY(BUSY2), .DONE(DONE2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // PE(j,i) sees A lane i delayed j more cycles and B lane j delayed i more cycles
    task automatic tick();
        @(posedge CLK);
        #1;
        for (int d = 3; d > 0; d--) begin
            ha[d] = ha[d-1];
            hb[d] = hb[d-1];
        end
        for (int i = 0; i < 4; i++) begin
            ha[0][i] = AA[i*8 +: 8];
            hb[0][i] = BB[i*8 +: 8];
        end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                acc[j][i] = PE_CLR ? 0 : acc[j][i] + int'(ha[j][i]) * int'(hb[i][j]);
    endtask

    // Beat number accepted at edge ed of a job (edge 0 is the START edge), 0 if none
    function automatic int beat_at(input int ed, input int klen, input bit bub);
        int k;
        if (bub && (ed % 2 == 0)) return 0;
        k = bub ? (ed - 1) / 2 : ed - 1;
        return (k >= 1 && k <= klen) ? k : 0;
    endfunction

    task automatic run_job(input int klen, input bit bub, input int abort_n);
        int last   = (klen == 0) ? 0 : (bub ? 2 * klen + 1 : klen + 1);
        int done_n = (klen == 0) ? 1 : last + F;
        int sq     = klen * (klen + 1) * (2 * klen + 1) / 6;
        int k;
        START = 1'b1; K_LEN = 8'(klen); IN_VALID = 1'b1;
        A_IN = 32'hEEEEEEEE; B_IN = 32'hDDDDDDDD;
        tick();
        for (int n = 0; n <= done_n + 2; n++) begin
            if (n == abort_n) begin
                #2 RST = 1'b0;
                #1;
                chk("abort_aa", AA, 0);
                chk("abort_bb", BB, 0);
                chk("abort_ready", IN_READY, 0);
                chk("abort_clr", PE_CLR, 0);
                chk("abort_busy", BUSY, 0);
                chk("abort_done", DONE, 0);
                START = 1'b0; IN_VALID = 1'b0;
                repeat (2) tick();
                RST = 1'b1;
                repeat (3) begin
                    tick();
                    chk("post_abort_busy", BUSY, 0);
                    chk("post_abort_done", DONE, 0);
                    chk("post_abort_aa", AA, 0);
                end
                return;
            end
            chk($sformatf("k%0d n%0d pe_clr", klen, n), PE_CLR, n == 0);
            chk($sformatf("k%0d n%0d ready", klen, n), IN_READY, n >= 1 && n < last);
            chk($sformatf("k%0d n%0d busy", klen, n), BUSY, n <= done_n);
            chk($sformatf("k%0d n%0d done", klen, n), DONE, n == done_n);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("k%0d n%0d aa%0d", klen, n, i), AA[i*8 +: 8], beat_at(n - i, klen, bub));
                chk($sformatf("k%0d n%0d bb%0d", klen, n, i), BB[i*8 +: 8], beat_at(n - i, klen, bub));
            end
            if (n == done_n && klen != 0)
                for (int j = 0; j < 4; j++)
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("k%0d sa_y%0d%0d", klen, j, i), acc[j][i], sq);
            k = beat_at(n + 1, klen, bub);
            START = (n <= done_n);
            K_LEN = (klen == 0) ? 8'd7 : 8'd0;
            IN_VALID = (k != 0) || (n >= last);
            A_IN = (k != 0) ? {4{8'(k)}} : 32'hEEEEEEEE;
            B_IN = (k != 0) ? {4{8'(k)}} : 32'hDDDDDDDD;
            tick();
        end
        START = 1'b0; IN_VALID = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b0;
        #2;
        chk("rst_aa", AA, 0);
        chk("rst_bb", BB, 0);
        chk("rst_ready", IN_READY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_clr", PE_CLR, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (6) begin
            tick();
            chk("idle_aa", AA, 0);
            chk("idle_bb", BB, 0);
            chk("idle_ready", IN_READY, 0);
            chk("idle_busy", BUSY, 0);
            chk("idle_done", DONE, 0);
            chk("idle_clr", PE_CLR, 0);
        end

        run_job(4, 1'b0, -1);
        run_job(4, 1'b1, -1);
        run_job(0, 1'b0, -1);
        run_job(4, 1'b0, 6);
        run_job(2, 1'b0, -1);
        run_job(255, 1'b0, -1);

        START2 = 1'b1; K_LEN2 = 8'd1;
        tick();
        chk("asym_clr", PE_CLR2, 1);
        chk("asym_busy0", BUSY2, 1);
        START2 = 1'b0; IN_VALID2 = 1'b1; A_IN2 = 16'h1211; B_IN2 = 24'h232221;
        tick();
        chk("asym_ready", IN_READY2, 1);
        chk("asym_aa_n1", AA2, 0);
        tick();
        A_IN2 = 16'hEEEE; B_IN2 = 24'hDDDDDD;
        for (int n = 2; n <= 9; n++) begin
            chk($sformatf("asym n%0d aa", n), AA2, n == 2 ? 16'h0011 : n == 3 ? 16'h1200 : 16'h0);
            chk($sformatf("asym n%0d bb", n), BB2,
                n == 2 ? 24'h000021 : n == 3 ? 24'h002200 : n == 4 ? 24'h230000 : 24'h0);
            chk($sformatf("asym n%0d ready", n), IN_READY2, 0);
            chk($sformatf("asym n%0d done", n), DONE2, n == 8);
            chk($sformatf("asym n%0d busy", n), BUSY2, n <= 8);
            tick();
        end
        IN_VALID2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Operand sequencer placed in front of the sa_2D output-stationary systolic array.
- Accepts one unskewed K-step beat per handshake: HPE A-lanes and VPE B-lanes.
- Applies the diagonal skew: lane i is delayed i cycles.
- Brackets each job with an accumulator clear and a zero flush, so the array result is final when DONE pulses. Generalises the hand-skewed stimulus the array needed until now.

Parameters:
- WIDTH, 8, operand width per lane (bits).
- HPE, 4, number of A lanes (array columns).
- VPE, 4, number of B lanes (array rows).
- KW, 8, width of the K_LEN job-length field.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  job start; sampled only in IDLE.
- K_LEN  input  KW  number of beats in the job; sampled with START.
- IN_VALID  input  1  beat valid.
- IN_READY  output  1  beat ready.
- A_IN  input  WIDTH*HPE  unskewed A beat; lane i = bits [(i+1)*WIDTH-1 : i*WIDTH].
- B_IN  input  WIDTH*VPE  unskewed B beat; same lane packing as A_IN.
- AA  output  WIDTH*HPE  skewed A to array; same lane packing.
- BB  output  WIDTH*VPE  skewed B to array; same lane packing.
- PE_CLR  output  1  accumulator clear to array.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; all skew registers, AA, BB = 0.
  - IN_READY=0, PE_CLR=0, BUSY=0, DONE=0; beat and flush counters = 0.
  - Reset mid-job aborts the job immediately; no DONE pulse is produced.
- States: IDLE, CLEAR, STREAM, FLUSH, FIN.
- IDLE:
  - START=1 → latch K_LEN, go to CLEAR.
  - START is ignored in all other states.
- CLEAR:
  - Exactly one cycle, PE_CLR=1.
  - Skew input is zero.
  - Next state: STREAM if latched K_LEN≠0, otherwise FIN.
- STREAM:
  - IN_READY=1 only in this state.
  - A beat is accepted on an edge where IN_VALID & IN_READY.
  - Accepted A_IN/B_IN enter skew stage 0. A cycle with no accepted beat injects an all-zero beat (bubble).
  - Bubbles preserve A/B alignment because both sides are zero for the same slot.
  - The beat counter increments per accepted beat. On the accept that makes count = K_LEN → FLUSH, IN_READY drops the next cycle.
- FLUSH:
  - Zero beats are injected for F = HPE + VPE + max(HPE,VPE) - 2 cycles (skew drain plus array propagation), then → FIN.
- FIN:
  - DONE=1 for one cycle, then → IDLE.
  - A START sampled in this cycle is ignored.
- Skew:
  - Lane i of A (and of B) passes through an (i+1)-deep register chain; the chain shifts every cycle in every non-reset state.
  - A beat accepted at edge e appears on AA/BB lane i during the cycle after edge e+i.
  - Lane 0 is therefore valid immediately after the accept edge.
  - Lanes beyond a side's own count do not exist: HPE≠VPE is legal and each side is skewed independently.
- Widths:
  - Pure data movement, no arithmetic on operands.
  - Counters are KW bits for the beat count and clog2(F+1) bits for the flush count.
  - K_LEN = 2^KW - 1 is legal.
- Stall:
  - IN_VALID may stay low for any number of STREAM cycles.
  - The job does not time out.

Test Plan:
- Reset idle, WIDTH=8, HPE=VPE=4: RST=0 then 1, no START → AA=BB=0, IN_READY=0, BUSY=0, DONE never asserts.
- Basic job: START with K_LEN=4; IN_VALID held 1; beats k=1..4 with every A/B lane = k:
  - PE_CLR high exactly one cycle, then IN_READY high for 4 cycles.
  - AA lane 3 shows 1,2,3,4 starting 3 cycles after lane 0 does.
  - DONE pulses 10 cycles after the last accept (F=10 flush cycles).
  - Driving sa_2D with these outputs gives Y_OUT[j][i] = 30 for every PE.
- Bubbles: same job with IN_VALID low every other cycle → lanes show data/zero interleave with identical per-lane offsets; the sa_2D result is unchanged (30 per PE); DONE arrives 4 cycles later than in the basic job.
- Zero-length job: START with K_LEN=0 → CLEAR (PE_CLR=1 for one cycle), then FIN; DONE follows PE_CLR by 1 cycle; IN_READY never rises.
- Abort: assert RST=0 during FLUSH → all outputs 0 asynchronously; after release state is IDLE; START with K_LEN=2 then runs a clean job.
- Asymmetric: HPE=2, VPE=3 → B lane 2 delay is 2 cycles, A max delay is 1 cycle; F = 2+3+3-2 = 6 flush cycles.
